// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the hazard controller: the scoreboard entry
// layout and the "does this entry produce the register I am reading" test.
`include "defines.sv"

package hazard_ctrl_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_en;
        logic       rs2_en;
    } sb_entry_t;

    // An entry is a producer for src only if it really writes a non-x0 register.
    function automatic logic sb_match(input sb_entry_t e, input logic [4:0] src,
                                      input logic en);
        return e.valid && e.reg_write && (e.rd != 5'd0) && en && (e.rd == src);
    endfunction

endpackage

// File: rtl/defines.sv
// Forwarding-select encodings shared by the hazard controller and its users.
`ifndef HAZARD_CTRL_DEFINES_SV
`define HAZARD_CTRL_DEFINES_SV

`define FORWARD_WIDTH 2
`define FORWARD_NONE  2'd0
`define FORWARD_MEM   2'd1
`define FORWARD_WB    2'd2

`endif

// File: rtl/hazard_ctrl_hz_fwd_sel.sv
// Per-operand forwarding select: MEM beats WB, and a load still in MEM is
// never a forwarding source (its data is not available yet).
`include "defines.sv"

module hz_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0]                i_src,
    input  logic                      i_src_en,
    input  sb_entry_t                 i_mem,
    input  sb_entry_t                 i_wb,
    output logic [`FORWARD_WIDTH-1:0] o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;
    logic w_unused;

    // Source-operand fields of the producer entries play no part in selection.
    assign w_unused = ^{i_mem.rs1, i_mem.rs2, i_mem.rs1_en, i_mem.rs2_en,
                        i_wb.rs1, i_wb.rs2, i_wb.rs1_en, i_wb.rs2_en, i_wb.mem_read};

    // Prioritised match: MEM (non-load) first, then WB, else no forwarding.
    always_comb begin
        w_mem_hit = sb_match(i_mem, i_src, i_src_en) && !i_mem.mem_read;
        w_wb_hit  = sb_match(i_wb, i_src, i_src_en);
        o_sel     = `FORWARD_NONE;
        if (w_mem_hit) begin
            o_sel = `FORWARD_MEM;
        end else if (w_wb_hit) begin
            o_sel = `FORWARD_WB;
        end else begin
            o_sel = `FORWARD_NONE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks the EX/MEM/WB producers in a small
// scoreboard, raises load-use and branch-operand stalls, flushes IF/ID on a
// taken branch, selects forwarding paths and counts stalls/flushes.
`include "defines.sv"

module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_rs1_rd_en,
    input  logic                      id_rs2_rd_en,
    input  logic [4:0]                id_rs1_addr,
    input  logic [4:0]                id_rs2_addr,
    input  logic [4:0]                id_rd_addr,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_is_branch,
    input  logic                      id_branch_taken,
    input  logic                      ext_stall,
    output logic                      stall_pc,
    output logic                      stall_if_id,
    output logic                      bubble_id_ex,
    output logic                      flush_if_id,
    output logic [`FORWARD_WIDTH-1:0] forward_op1,
    output logic [`FORWARD_WIDTH-1:0] forward_op2,
    output logic [`FORWARD_WIDTH-1:0] ex_forward_op1,
    output logic [`FORWARD_WIDTH-1:0] ex_forward_op2,
    output logic [31:0]               stall_count,
    output logic [31:0]               flush_count
);

    sb_entry_t r_ex, r_mem, r_wb;
    sb_entry_t w_id;
    logic      w_ex_hit, w_mem_hit;
    logic      w_load_use, w_branch_hz, w_hz;
    logic [31:0] r_stall_count, r_flush_count;
    logic [`FORWARD_WIDTH-1:0] w_fwd1, w_fwd2, w_ex_fwd1, w_ex_fwd2;

    // Snapshot of the instruction currently in ID, as it would enter EX.
    always_comb begin
        w_id = '{valid: 1'b1, rd: id_rd_addr, reg_write: id_reg_write,
                 mem_read: id_mem_read, rs1: id_rs1_addr, rs2: id_rs2_addr,
                 rs1_en: id_rs1_rd_en, rs2_en: id_rs2_rd_en};
    end

    // Hazard detection: loads in EX block any consumer; branches resolve in ID
    // so they also wait on an ALU result in EX or a load result in MEM.
    always_comb begin
        w_ex_hit    = sb_match(r_ex, id_rs1_addr, id_rs1_rd_en) ||
                      sb_match(r_ex, id_rs2_addr, id_rs2_rd_en);
        w_mem_hit   = sb_match(r_mem, id_rs1_addr, id_rs1_rd_en) ||
                      sb_match(r_mem, id_rs2_addr, id_rs2_rd_en);
        w_load_use  = r_ex.mem_read && w_ex_hit;
        w_branch_hz = id_is_branch && (w_ex_hit || (r_mem.mem_read && w_mem_hit));
        w_hz        = w_load_use || w_branch_hz;
    end

    hz_fwd_sel u_fwd_id1 (.i_src(id_rs1_addr), .i_src_en(id_rs1_rd_en),
                          .i_mem(r_mem), .i_wb(r_wb), .o_sel(w_fwd1));
    hz_fwd_sel u_fwd_id2 (.i_src(id_rs2_addr), .i_src_en(id_rs2_rd_en),
                          .i_mem(r_mem), .i_wb(r_wb), .o_sel(w_fwd2));
    hz_fwd_sel u_fwd_ex1 (.i_src(r_ex.rs1), .i_src_en(r_ex.rs1_en),
                          .i_mem(r_mem), .i_wb(r_wb), .o_sel(w_ex_fwd1));
    hz_fwd_sel u_fwd_ex2 (.i_src(r_ex.rs2), .i_src_en(r_ex.rs2_en),
                          .i_mem(r_mem), .i_wb(r_wb), .o_sel(w_ex_fwd2));

    // Pipeline control: reset silences everything, memory busy freezes all,
    // a hazard stalls with a bubble, otherwise a taken branch flushes IF/ID.
    always_comb begin
        stall_pc       = 1'b0;
        stall_if_id    = 1'b0;
        bubble_id_ex   = 1'b0;
        flush_if_id    = 1'b0;
        forward_op1    = `FORWARD_NONE;
        forward_op2    = `FORWARD_NONE;
        ex_forward_op1 = `FORWARD_NONE;
        ex_forward_op2 = `FORWARD_NONE;
        if (rst) begin
            stall_pc = 1'b0;
        end else begin
            forward_op1    = w_fwd1;
            forward_op2    = w_fwd2;
            ex_forward_op1 = w_ex_fwd1;
            ex_forward_op2 = w_ex_fwd2;
            if (ext_stall) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
            end else if (w_hz) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end else if (id_branch_taken) begin
                flush_if_id = 1'b1;
            end else begin
                flush_if_id = 1'b0;
            end
        end
    end

    // Scoreboard shift: hold on memory busy, insert an empty EX slot on a hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (!ext_stall) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_hz ? sb_entry_t'('0) : w_id;
        end else begin
            r_ex  <= r_ex;
            r_mem <= r_mem;
            r_wb  <= r_wb;
        end
    end

    // Saturating stall/flush performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= 32'd0;
            r_flush_count <= 32'd0;
        end else begin
            if (w_hz && !ext_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (flush_if_id && (r_flush_count != 32'hFFFF_FFFF)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: short instruction sequences with
// hand-derived control, forwarding and counter expectations.
module tb_hazard_ctrl;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_MEM  = 2'd1;
    localparam logic [1:0] FWD_WB   = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_rs1_rd_en = 1'b0, id_rs2_rd_en = 1'b0;
    logic [4:0]  id_rs1_addr = 5'd0, id_rs2_addr = 5'd0, id_rd_addr = 5'd0;
    logic        id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic        id_is_branch = 1'b0, id_branch_taken = 1'b0;
    logic        ext_stall = 1'b0;
    logic        stall_pc, stall_if_id, bubble_id_ex, flush_if_id;
    logic [1:0]  forward_op1, forward_op2, ex_forward_op1, ex_forward_op2;
    logic [31:0] stall_count, flush_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1_rd_en(id_rs1_rd_en), .id_rs2_rd_en(id_rs2_rd_en),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
        .ext_stall(ext_stall),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
        .flush_if_id(flush_if_id),
        .forward_op1(forward_op1), .forward_op2(forward_op2),
        .ex_forward_op1(ex_forward_op1), .ex_forward_op2(ex_forward_op2),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // Put one instruction into ID.
    task automatic set_id(input logic r1en, input logic [4:0] r1, input logic r2en,
                          input logic [4:0] r2, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic br, input logic tk);
        id_rs1_rd_en = r1en; id_rs1_addr = r1;
        id_rs2_rd_en = r2en; id_rs2_addr = r2;
        id_rd_addr = rd; id_reg_write = rw; id_mem_read = mr;
        id_is_branch = br; id_branch_taken = tk;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ext_stall = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_id(1'b1, 5'd3, 1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        step(); step();
        checks++;
        if ({stall_pc, stall_if_id, bubble_id_ex, flush_if_id} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got=%b want=0000",
                {stall_pc, stall_if_id, bubble_id_ex, flush_if_id});
        end
        checks++;
        if ({forward_op1, forward_op2, ex_forward_op1, ex_forward_op2} !== 8'h00) begin
            errors++; $display("FAIL reset_fwd got=%h want=00",
                {forward_op1, forward_op2, ex_forward_op1, ex_forward_op2});
        end
        checks++;
        if ({stall_count, flush_count} !== 64'd0) begin
            errors++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", stall_count, flush_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 5'd1, 1'b0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); // lw x5,0(x1)
        checks++;
        if ({stall_pc, stall_if_id, bubble_id_ex, flush_if_id} !== 4'b0000) begin
            errors++; $display("FAIL lu_first got=%b want=0000",
                {stall_pc, stall_if_id, bubble_id_ex, flush_if_id});
        end
        step();
        set_id(1'b1, 5'd5, 1'b1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); // add x6,x5,x2
        checks++;
        if ({stall_pc, stall_if_id, bubble_id_ex, flush_if_id} !== 4'b1110) begin
            errors++; $display("FAIL lu_stall got=%b want=1110",
                {stall_pc, stall_if_id, bubble_id_ex, flush_if_id});
        end
        step();
        checks++;
        if ({stall_pc, bubble_id_ex, forward_op1} !== {1'b0, 1'b0, FWD_NONE}) begin
            errors++; $display("FAIL lu_release got=%b want=0000",
                {stall_pc, bubble_id_ex, forward_op1});
        end
        step();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({ex_forward_op1, ex_forward_op2} !== {FWD_WB, FWD_NONE}) begin
            errors++; $display("FAIL lu_exfwd got=%b want=%b",
                {ex_forward_op1, ex_forward_op2}, {FWD_WB, FWD_NONE});
        end
        checks++;
        if ({stall_count, flush_count} !== {32'd1, 32'd0}) begin
            errors++; $display("FAIL lu_cnt got=%0d/%0d want=1/0", stall_count, flush_count);
        end
    endtask

    task automatic test_alu_branch();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); // addi x3,x0,4
        step();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); // beq x3,x0
        checks++;
        if ({stall_pc, stall_if_id, bubble_id_ex, flush_if_id} !== 4'b1110) begin
            errors++; $display("FAIL ab_stall got=%b want=1110",
                {stall_pc, stall_if_id, bubble_id_ex, flush_if_id});
        end
        step();
        checks++;
        if ({stall_pc, forward_op1, forward_op2} !== {1'b0, FWD_MEM, FWD_NONE}) begin
            errors++; $display("FAIL ab_fwd got=%b want=%b",
                {stall_pc, forward_op1, forward_op2}, {1'b0, FWD_MEM, FWD_NONE});
        end
        checks++;
        if (stall_count !== 32'd1) begin
            errors++; $display("FAIL ab_cnt got=%0d want=1", stall_count);
        end
    endtask

    task automatic test_load_branch();
        do_reset();
        set_id(1'b1, 5'd1, 1'b0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0); // lw x3
        step();
        set_id(1'b1, 5'd3, 1'b1, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); // bne x3,x4
        checks++;
        if ({stall_pc, bubble_id_ex} !== 2'b11) begin
            errors++; $display("FAIL lb_stall1 got=%b want=11", {stall_pc, bubble_id_ex});
        end
        step();
        checks++;
        if ({stall_pc, bubble_id_ex} !== 2'b11) begin
            errors++; $display("FAIL lb_stall2 got=%b want=11", {stall_pc, bubble_id_ex});
        end
        step();
        checks++;
        if ({stall_pc, forward_op1} !== {1'b0, FWD_WB}) begin
            errors++; $display("FAIL lb_release got=%b want=%b",
                {stall_pc, forward_op1}, {1'b0, FWD_WB});
        end
        checks++;
        if (stall_count !== 32'd2) begin
            errors++; $display("FAIL lb_cnt got=%0d want=2", stall_count);
        end
    endtask

    task automatic test_x0_priority();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); // addi x0,x0,1
        step();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); // beq x0,x0
        checks++;
        if ({stall_pc, forward_op1} !== {1'b0, FWD_NONE}) begin
            errors++; $display("FAIL x0 got=%b want=000", {stall_pc, forward_op1});
        end
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); // addi x7
        step();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); // addi x7
        step();
        set_id(1'b1, 5'd7, 1'b1, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); // add x8,x7,x7
        checks++;
        if ({stall_pc, forward_op1, forward_op2} !== {1'b0, FWD_MEM, FWD_MEM}) begin
            errors++; $display("FAIL prio_id got=%b want=%b",
                {stall_pc, forward_op1, forward_op2}, {1'b0, FWD_MEM, FWD_MEM});
        end
        step();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({ex_forward_op1, ex_forward_op2} !== {FWD_MEM, FWD_MEM}) begin
            errors++; $display("FAIL prio_ex got=%b want=%b",
                {ex_forward_op1, ex_forward_op2}, {FWD_MEM, FWD_MEM});
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1); // jal taken
        checks++;
        if ({stall_pc, stall_if_id, bubble_id_ex, flush_if_id} !== 4'b0001) begin
            errors++; $display("FAIL jal_flush got=%b want=0001",
                {stall_pc, stall_if_id, bubble_id_ex, flush_if_id});
        end
        step();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({flush_if_id, flush_count} !== {1'b0, 32'd1}) begin
            errors++; $display("FAIL jal_cnt got=%b/%0d want=0/1", flush_if_id, flush_count);
        end
    endtask

    task automatic test_ext_stall();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0); // addi x9
        step();
        ext_stall = 1'b1;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1); // jal taken
        checks++;
        if ({stall_pc, stall_if_id, bubble_id_ex, flush_if_id} !== 4'b1100) begin
            errors++; $display("FAIL ext_ctrl got=%b want=1100",
                {stall_pc, stall_if_id, bubble_id_ex, flush_if_id});
        end
        step();
        ext_stall = 1'b0;
        // addi x9 must still sit in EX, so a branch on x9 stalls and MEM is empty
        set_id(1'b1, 5'd9, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({stall_pc, forward_op1} !== {1'b1, FWD_NONE}) begin
            errors++; $display("FAIL ext_hold got=%b want=%b",
                {stall_pc, forward_op1}, {1'b1, FWD_NONE});
        end
        checks++;
        if ({stall_count, flush_count} !== {32'd0, 32'd0}) begin
            errors++; $display("FAIL ext_cnt got=%0d/%0d want=0/0", stall_count, flush_count);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1'b1, 5'd1, 1'b0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); // lw x5
        step();
        set_id(1'b1, 5'd5, 1'b1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); // add x6,x5,x2
        checks++;
        if (bubble_id_ex !== 1'b1) begin
            errors++; $display("FAIL mid_pre got=%b want=1", bubble_id_ex);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({stall_pc, stall_if_id, bubble_id_ex, flush_if_id, stall_count, flush_count}
                !== {4'b0000, 64'd0}) begin
            errors++; $display("FAIL mid_rst got=%b/%0d/%0d want=0000/0/0",
                {stall_pc, stall_if_id, bubble_id_ex, flush_if_id}, stall_count, flush_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({stall_pc, bubble_id_ex, forward_op1, forward_op2} !== 6'b000000) begin
            errors++; $display("FAIL mid_after got=%b want=000000",
                {stall_pc, bubble_id_ex, forward_op1, forward_op2});
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu_branch();
        test_load_branch();
        test_x0_priority();
        test_flush();
        test_ext_stall();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
